// File: rtl/superga_pkg.sv
// Shared definitions for the SuperGA pixel pipeline: screen defaults,
// colour width, write-stage FSM encoding and a width helper.
package superga_pkg;

  localparam int X_RESOL_DEF = 320;
  localparam int Y_RESOL_DEF = 200;
  localparam int COL_W_DEF   = 8;

  // Write-stage FSM encoding
  localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
  localparam logic [1:0] ST_WRITE_ENC = 2'd1;
  localparam logic [1:0] ST_CLEAR_ENC = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = ST_IDLE_ENC,
    ST_WRITE = ST_WRITE_ENC,
    ST_CLEAR = ST_CLEAR_ENC
  } wr_state_t;

  // Bits needed to index n items (never less than 1)
  function automatic int clog2_min1(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

  localparam int ADDR_W_MIN = clog2_min1(X_RESOL_DEF * Y_RESOL_DEF);

endpackage

// File: rtl/pixel_writer_if.sv
// Bus bundles for the framebuffer write stage: the pixel stream from the
// screen-coordinate mapper and the req/ack framebuffer write port.

// Pixel stream; the mapper is the master and cannot be stalled.
interface pix_if #(
  parameter int COL_W = superga_pkg::COL_W_DEF
);
  logic [15:0]      PIX_X;
  logic [15:0]      PIX_Y;
  logic             PIX_VALID;
  logic [COL_W-1:0] PIX_COLOR;

  modport master (output PIX_X, PIX_Y, PIX_VALID, PIX_COLOR);
  modport slave  (input  PIX_X, PIX_Y, PIX_VALID, PIX_COLOR);
endinterface

// Framebuffer write port; the writer is the master, memory answers with ACK.
interface mem_if #(
  parameter int ADDR_W = 17,
  parameter int COL_W  = superga_pkg::COL_W_DEF
);
  logic [ADDR_W-1:0] MEM_ADDR;
  logic [COL_W-1:0]  MEM_DATA;
  logic              MEM_WE;
  logic              MEM_ACK;

  modport master (output MEM_ADDR, MEM_DATA, MEM_WE, input  MEM_ACK);
  modport slave  (input  MEM_ADDR, MEM_DATA, MEM_WE, output MEM_ACK);
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead read data. A push while full is
// discarded even if a pop happens in the same cycle.
module sync_fifo
  import superga_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             ACLK,
  input  logic             ARESETN,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = clog2_min1(DEPTH);

  logic [WIDTH-1:0] mem_array [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic             wr_en;
  logic             rd_en;

  assign full    = (count_reg == (PTR_W+1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign wr_en   = push & ~full;
  assign rd_en   = pop & ~empty;
  assign rd_data = mem_array[rd_ptr_reg];

  // Storage write; contents need no reset since count gates every read
  always_ff @(posedge ACLK) begin
    if (wr_en) mem_array[wr_ptr_reg] <= wr_data;
  end

  // Pointer and occupancy tracking
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (rd_en) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_reg + {{PTR_W{1'b0}}, wr_en} - {{PTR_W{1'b0}}, rd_en};
    end
  end

endmodule

// File: rtl/pixel_writer.sv
// Framebuffer write stage: buffers in-range pixels, linearises (x,y) into
// a framebuffer address, drives the req/ack write port and can clear the
// whole frame to a background colour.
module pixel_writer
  import superga_pkg::*;
#(
  parameter int X_RESOL    = X_RESOL_DEF,
  parameter int Y_RESOL    = Y_RESOL_DEF,
  parameter int ADDR_W     = 17,
  parameter int COL_W      = COL_W_DEF,
  parameter int FIFO_DEPTH = 16
) (
  input  logic             ACLK,
  input  logic             ARESETN,
  pix_if.slave             pix,
  mem_if.master            mem,
  input  logic             CLEAR,
  input  logic [COL_W-1:0] BG_COLOR,
  output logic             BUSY,
  output logic             CLR_DONE,
  output logic [15:0]      DROP_CNT
);

  localparam int                FRAME_PIX = X_RESOL * Y_RESOL;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIX - 1);
  localparam int                ENTRY_W   = ADDR_W + COL_W;

  wr_state_t         state_reg,    state_next;
  logic [ADDR_W-1:0] addr_reg,     addr_next;
  logic [COL_W-1:0]  data_reg,     data_next;
  logic              we_reg,       we_next;
  logic              clr_pend_reg, clr_pend_next;
  logic              clr_done_reg, clr_done_next;
  logic [15:0]       drop_cnt_reg;

  logic              in_range;
  logic [ADDR_W-1:0] pix_addr;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic              drop_evt;
  logic [ENTRY_W-1:0] fifo_wr_data;
  logic [ENTRY_W-1:0] fifo_rd_data;
  logic [ADDR_W-1:0] head_addr;
  logic [COL_W-1:0]  head_data;

  // Coordinate check and linear address; y only matters when in range,
  // so truncating it to ADDR_W first is safe.
  assign in_range  = (pix.PIX_X < 16'(X_RESOL)) && (pix.PIX_Y < 16'(Y_RESOL));
  assign pix_addr  = ADDR_W'(pix.PIX_Y) * ADDR_W'(X_RESOL) + ADDR_W'(pix.PIX_X);
  assign fifo_push = pix.PIX_VALID && in_range;
  assign drop_evt  = pix.PIX_VALID && (!in_range || fifo_full);
  assign fifo_wr_data = {pix_addr, pix.PIX_COLOR};
  assign {head_addr, head_data} = fifo_rd_data;

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .ACLK    (ACLK),
    .ARESETN (ARESETN),
    .push    (fifo_push),
    .wr_data (fifo_wr_data),
    .pop     (fifo_pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Saturating count of discarded samples
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      drop_cnt_reg <= '0;
    end else if (drop_evt && (drop_cnt_reg != 16'hFFFF)) begin
      drop_cnt_reg <= drop_cnt_reg + 1'b1;
    end
  end

  // FSM state and write-port registers
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_reg    <= ST_IDLE;
      addr_reg     <= '0;
      data_reg     <= '0;
      we_reg       <= 1'b0;
      clr_pend_reg <= 1'b0;
      clr_done_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      addr_reg     <= addr_next;
      data_reg     <= data_next;
      we_reg       <= we_next;
      clr_pend_reg <= clr_pend_next;
      clr_done_reg <= clr_done_next;
    end
  end

  // Next-state logic: a pending clear wins over buffered pixels, and a
  // clear request seen while already clearing is ignored.
  always_comb begin
    state_next    = state_reg;
    addr_next     = addr_reg;
    data_next     = data_reg;
    we_next       = we_reg;
    clr_done_next = 1'b0;
    fifo_pop      = 1'b0;
    clr_pend_next = clr_pend_reg | (CLEAR && (state_reg != ST_CLEAR));

    case (state_reg)
      ST_IDLE: begin
        if (clr_pend_reg) begin
          state_next    = ST_CLEAR;
          addr_next     = '0;
          data_next     = BG_COLOR;
          we_next       = 1'b1;
          clr_pend_next = 1'b0;
        end else if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          addr_next  = head_addr;
          data_next  = head_data;
          we_next    = 1'b1;
          state_next = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (mem.MEM_ACK) begin
          if (clr_pend_reg) begin
            state_next    = ST_CLEAR;
            addr_next     = '0;
            data_next     = BG_COLOR;
            we_next       = 1'b1;
            clr_pend_next = 1'b0;
          end else if (!fifo_empty) begin
            fifo_pop  = 1'b1;
            addr_next = head_addr;
            data_next = head_data;
          end else begin
            we_next    = 1'b0;
            state_next = ST_IDLE;
          end
        end
      end
      ST_CLEAR: begin
        if (mem.MEM_ACK) begin
          if (addr_reg == LAST_ADDR) begin
            we_next       = 1'b0;
            clr_done_next = 1'b1;
            state_next    = ST_IDLE;
          end else begin
            addr_next = addr_reg + 1'b1;
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
        we_next    = 1'b0;
      end
    endcase
  end

  assign mem.MEM_ADDR = addr_reg;
  assign mem.MEM_DATA = data_reg;
  assign mem.MEM_WE   = we_reg;
  assign CLR_DONE     = clr_done_reg;
  assign DROP_CNT     = drop_cnt_reg;
  assign BUSY         = !fifo_empty || we_reg || clr_pend_reg || (state_reg != ST_IDLE);

endmodule

// File: tb/tb_pixel_writer.sv
// Directed bench for pixel_writer: a full-size instance (320x200) and a
// tiny-frame instance (4x2) for the clear sequences.
`timescale 1ns/1ps
module tb_pixel_writer;

  logic ACLK = 1'b0;
  logic ARESETN = 1'b0;
  always #5 ACLK = ~ACLK;

  // Full-size instance
  pix_if #(.COL_W(8)) pix_b ();
  mem_if #(.ADDR_W(17), .COL_W(8)) mem_b ();
  logic        clear_b, busy_b, clr_done_b;
  logic [7:0]  bg_b;
  logic [15:0] drop_b;

  pixel_writer #(.X_RESOL(320), .Y_RESOL(200), .ADDR_W(17), .COL_W(8), .FIFO_DEPTH(16)) dut_big (
    .ACLK(ACLK), .ARESETN(ARESETN), .pix(pix_b), .mem(mem_b),
    .CLEAR(clear_b), .BG_COLOR(bg_b), .BUSY(busy_b), .CLR_DONE(clr_done_b), .DROP_CNT(drop_b)
  );

  // Tiny-frame instance
  pix_if #(.COL_W(8)) pix_s ();
  mem_if #(.ADDR_W(3), .COL_W(8)) mem_s ();
  logic        clear_s, busy_s, clr_done_s;
  logic [7:0]  bg_s;
  logic [15:0] drop_s;

  pixel_writer #(.X_RESOL(4), .Y_RESOL(2), .ADDR_W(3), .COL_W(8), .FIFO_DEPTH(16)) dut_small (
    .ACLK(ACLK), .ARESETN(ARESETN), .pix(pix_s), .mem(mem_s),
    .CLEAR(clear_s), .BG_COLOR(bg_s), .BUSY(busy_s), .CLR_DONE(clr_done_s), .DROP_CNT(drop_s)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic [7:0]  col;
    logic        exp_wr;
    logic [16:0] exp_addr;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic drive_b(input int x, input int y, input logic [7:0] c);
    pix_b.PIX_X = 16'(x);
    pix_b.PIX_Y = 16'(y);
    pix_b.PIX_COLOR = c;
    pix_b.PIX_VALID = 1'b1;
  endtask

  task automatic drive_s(input int x, input int y, input logic [7:0] c);
    pix_s.PIX_X = 16'(x);
    pix_s.PIX_Y = 16'(y);
    pix_s.PIX_COLOR = c;
    pix_s.PIX_VALID = 1'b1;
  endtask

  task automatic do_reset();
    ARESETN = 1'b0;
    pix_b.PIX_VALID = 1'b0; pix_b.PIX_X = '0; pix_b.PIX_Y = '0; pix_b.PIX_COLOR = '0;
    pix_s.PIX_VALID = 1'b0; pix_s.PIX_X = '0; pix_s.PIX_Y = '0; pix_s.PIX_COLOR = '0;
    mem_b.MEM_ACK = 1'b0; mem_s.MEM_ACK = 1'b0;
    clear_b = 1'b0; clear_s = 1'b0; bg_b = '0; bg_s = '0;
    tick();
    tick();
    ARESETN = 1'b1;
    tick();
  endtask

  // Runs a tiny-frame clear with ACK high and expects 8 writes of bg then one CLR_DONE
  task automatic run_small_clear(input logic [7:0] bg, input string tag);
    int nw;
    int ndone;
    bg_s = bg;
    mem_s.MEM_ACK = 1'b1;
    clear_s = 1'b1;
    tick();
    clear_s = 1'b0;
    nw = 0;
    ndone = 0;
    for (int c = 0; c < 20; c++) begin
      if (mem_s.MEM_WE) begin
        if (nw < 8) begin
          check($sformatf("%s addr%0d", tag, nw), 32'(mem_s.MEM_ADDR), 32'(nw));
          check($sformatf("%s data%0d", tag, nw), 32'(mem_s.MEM_DATA), 32'(bg));
        end
        nw++;
      end
      if (clr_done_s) ndone++;
      tick();
    end
    check({tag, " write count"}, 32'(nw), 32'd8);
    check({tag, " clr_done pulses"}, 32'(ndone), 32'd1);
  endtask

  initial begin
    int exp_drop;
    int nw;
    int ndone;
    bit found;
    logic [2:0] s_addr [10];
    logic [7:0] s_data [10];

    vecs[0] = '{x:16'd10,     y:16'd5,      col:8'h3C, exp_wr:1'b1, exp_addr:17'd1610};
    vecs[1] = '{x:16'd319,    y:16'd199,    col:8'hA5, exp_wr:1'b1, exp_addr:17'd63999};
    vecs[2] = '{x:16'd320,    y:16'd0,      col:8'h11, exp_wr:1'b0, exp_addr:17'd0};
    vecs[3] = '{x:16'd0,      y:16'd0,      col:8'hFF, exp_wr:1'b1, exp_addr:17'd0};
    vecs[4] = '{x:16'd0,      y:16'd200,    col:8'h22, exp_wr:1'b0, exp_addr:17'd0};
    vecs[5] = '{x:16'd100,    y:16'd100,    col:8'h5A, exp_wr:1'b1, exp_addr:17'd32100};
    vecs[6] = '{x:16'hFFFF,   y:16'hFFFF,   col:8'h33, exp_wr:1'b0, exp_addr:17'd0};
    vecs[7] = '{x:16'd319,    y:16'd0,      col:8'h77, exp_wr:1'b1, exp_addr:17'd319};
    vecs[8] = '{x:16'd0,      y:16'd199,    col:8'h88, exp_wr:1'b1, exp_addr:17'd63680};

    // Reset values
    do_reset();
    ARESETN = 1'b0;
    #1;
    check("rst we",       32'(mem_b.MEM_WE),   32'd0);
    check("rst addr",     32'(mem_b.MEM_ADDR), 32'd0);
    check("rst data",     32'(mem_b.MEM_DATA), 32'd0);
    check("rst busy",     32'(busy_b),         32'd0);
    check("rst clr_done", 32'(clr_done_b),     32'd0);
    check("rst drop",     32'(drop_b),         32'd0);
    do_reset();

    // Single pixels with ACK tied high
    mem_b.MEM_ACK = 1'b1;
    exp_drop = 0;
    for (int i = 0; i < 9; i++) begin
      drive_b(int'(vecs[i].x), int'(vecs[i].y), vecs[i].col);
      tick();
      pix_b.PIX_VALID = 1'b0;
      if (!vecs[i].exp_wr) exp_drop++;
      check($sformatf("v%0d drop", i), 32'(drop_b), 32'(exp_drop));
      check($sformatf("v%0d busy", i), 32'(busy_b), 32'(vecs[i].exp_wr));
      tick();
      check($sformatf("v%0d we", i), 32'(mem_b.MEM_WE), 32'(vecs[i].exp_wr));
      if (vecs[i].exp_wr) begin
        check($sformatf("v%0d addr", i), 32'(mem_b.MEM_ADDR), 32'(vecs[i].exp_addr));
        check($sformatf("v%0d data", i), 32'(mem_b.MEM_DATA), 32'(vecs[i].col));
      end
      tick();
      check($sformatf("v%0d we after ack", i), 32'(mem_b.MEM_WE), 32'd0);
      check($sformatf("v%0d idle busy", i), 32'(busy_b), 32'd0);
    end

    // FIFO overflow: one pixel held in the write register, then 20 samples
    do_reset();
    mem_b.MEM_ACK = 1'b0;
    drive_b(1, 0, 8'h40);
    tick();
    pix_b.PIX_VALID = 1'b0;
    tick();
    check("ovf held we",   32'(mem_b.MEM_WE),   32'd1);
    check("ovf held addr", 32'(mem_b.MEM_ADDR), 32'd1);
    for (int i = 0; i < 20; i++) begin
      drive_b(10 + i, 1, 8'(8'h80 + i));
      tick();
    end
    pix_b.PIX_VALID = 1'b0;
    check("ovf drop", 32'(drop_b), 32'd4);
    check("ovf addr stable", 32'(mem_b.MEM_ADDR), 32'd1);
    check("ovf data stable", 32'(mem_b.MEM_DATA), 32'h40);
    mem_b.MEM_ACK = 1'b1;
    nw = 0;
    for (int c = 0; c < 40; c++) begin
      if (mem_b.MEM_WE) begin
        if (nw == 0) begin
          check("ovf w0 addr", 32'(mem_b.MEM_ADDR), 32'd1);
          check("ovf w0 data", 32'(mem_b.MEM_DATA), 32'h40);
        end else if (nw < 17) begin
          check($sformatf("ovf w%0d addr", nw), 32'(mem_b.MEM_ADDR), 32'(329 + nw));
          check($sformatf("ovf w%0d data", nw), 32'(mem_b.MEM_DATA), 32'(8'h7F + nw));
        end
        nw++;
      end
      tick();
    end
    check("ovf write count", 32'(nw), 32'd17);
    check("ovf busy end", 32'(busy_b), 32'd0);

    // Tiny-frame clear with pixels arriving mid-clear and a second CLEAR ignored
    do_reset();
    for (int i = 0; i < 8; i++) begin
      s_addr[i] = 3'(i);
      s_data[i] = 8'h00;
    end
    s_addr[8] = 3'd5; s_data[8] = 8'hC1;
    s_addr[9] = 3'd3; s_data[9] = 8'hC2;
    bg_s = 8'h00;
    mem_s.MEM_ACK = 1'b1;
    clear_s = 1'b1;
    tick();
    clear_s = 1'b0;
    nw = 0;
    ndone = 0;
    for (int c = 0; c < 30; c++) begin
      pix_s.PIX_VALID = 1'b0;
      if (c == 2) drive_s(1, 1, 8'hC1);
      if (c == 3) drive_s(3, 0, 8'hC2);
      clear_s = (c == 5);
      if (mem_s.MEM_WE) begin
        if (nw < 10) begin
          check($sformatf("clr w%0d addr", nw), 32'(mem_s.MEM_ADDR), 32'(s_addr[nw]));
          check($sformatf("clr w%0d data", nw), 32'(mem_s.MEM_DATA), 32'(s_data[nw]));
        end
        nw++;
      end
      if (clr_done_s) begin
        ndone++;
        check("clr_done after last clear write", 32'(nw), 32'd8);
      end
      tick();
    end
    check("clr total writes", 32'(nw), 32'd10);
    check("clr_done pulses", 32'(ndone), 32'd1);
    check("clr drop", 32'(drop_s), 32'd0);

    // CLEAR while a pixel write waits for ACK
    do_reset();
    mem_b.MEM_ACK = 1'b0;
    drive_b(2, 0, 8'h99);
    tick();
    pix_b.PIX_VALID = 1'b0;
    tick();
    bg_b = 8'h5E;
    clear_b = 1'b1;
    tick();
    clear_b = 1'b0;
    tick();
    tick();
    check("pend we",   32'(mem_b.MEM_WE),   32'd1);
    check("pend addr", 32'(mem_b.MEM_ADDR), 32'd2);
    check("pend data", 32'(mem_b.MEM_DATA), 32'h99);
    check("pend busy", 32'(busy_b),         32'd1);
    mem_b.MEM_ACK = 1'b1;
    tick();
    mem_b.MEM_ACK = 1'b0;
    check("clr start we",   32'(mem_b.MEM_WE),   32'd1);
    check("clr start addr", 32'(mem_b.MEM_ADDR), 32'd0);
    check("clr start data", 32'(mem_b.MEM_DATA), 32'h5E);
    tick();
    check("clr hold addr", 32'(mem_b.MEM_ADDR), 32'd0);

    // Reset in the middle of a tiny-frame clear
    do_reset();
    bg_s = 8'h33;
    mem_s.MEM_ACK = 1'b1;
    clear_s = 1'b1;
    tick();
    clear_s = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      if (mem_s.MEM_WE && (mem_s.MEM_ADDR == 3'd3)) found = 1'b1;
      else tick();
    end
    check("mid-clear addr3 reached", 32'(found), 32'd1);
    ARESETN = 1'b0;
    #1;
    check("arst we",       32'(mem_s.MEM_WE),   32'd0);
    check("arst addr",     32'(mem_s.MEM_ADDR), 32'd0);
    check("arst data",     32'(mem_s.MEM_DATA), 32'd0);
    check("arst busy",     32'(busy_s),         32'd0);
    check("arst clr_done", 32'(clr_done_s),     32'd0);
    tick();
    tick();
    ARESETN = 1'b1;
    nw = 0;
    ndone = 0;
    for (int c = 0; c < 12; c++) begin
      if (mem_s.MEM_WE) nw++;
      if (clr_done_s) ndone++;
      tick();
    end
    check("post-rst writes", 32'(nw), 32'd0);
    check("post-rst clr_done", 32'(ndone), 32'd0);
    run_small_clear(8'h33, "reclear");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time limit so the run always reaches a summary
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish before 200000ns");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "timeout");
  end

endmodule
